frac_engine_mj: RTL and testbench
=================================

FRAC_ENGINE_MJ -- requirements
Module: frac_engine_mj

Interface
REQ-001 Parameter: W, 32, total width of signed Qm.f operands.
REQ-002 Parameter: M, 4, integer bits incl. sign; F = W-M fraction bits.
REQ-003 Parameter: IW, 16, iteration counter width.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request new pixel; sampled only when ready=1.
REQ-007 mode  input  1  0 = Mandelbrot, 1 = Julia; sampled with start.
REQ-008 cx, cy  input  W each  pixel coordinate, Qm.f.
REQ-009 jx, jy  input  W each  Julia constant, Qm.f; sampled with start.
REQ-010 max_it  input  IW  iteration limit; sampled with start.
REQ-011 esc_thr  input  W  escape threshold on x²+y², Qm.f, unsigned-positive; sampled with start.
REQ-012 abort  input  1  cancel current pixel.
REQ-013 ready  output  1  engine idle, start accepted.
REQ-014 busy  output  1  iterating.
REQ-015 res_valid / res_ready  output / input  1 each  result handshake.
REQ-016 res_iter  output  IW  iterations executed.
REQ-017 res_escaped  output  1  1 = escaped or overflowed, 0 = hit max_it.
REQ-018 done_tick  output  1  one-cycle pulse on the cycle res_valid first rises.

Function
REQ-019 States IDLE, OP, DONE; ready=1 only in IDLE, busy=1 only in OP, res_valid=1 only in DONE.
REQ-020 IDLE & start: latch inputs; z=(cx,cy); k=(cx,cy) if mode=0, k=(jx,jy) if mode=1; iter=0; go to OP, or to DONE with iter=0, escaped=0 if max_it=0.
REQ-021 Each OP cycle: from current z compute xx, yy, 2xy (truncated to Qm.f); z <= (xx-yy+kx, 2xy+ky); iter <= iter+1.
REQ-022 Escape in OP cycle = (xx+yy, computed in W+1 bits, > esc_thr) OR multiplier overflow (discarded upper raw bits not sign-extension of result).
REQ-023 OP exits to DONE when escape=1 (escaped=1) or iter+1 == max_it (escaped=0); escape wins if both; iter reported includes the exiting cycle.
REQ-024 Latency: res_valid rises the cycle after the exiting OP cycle; N iterations -> res_valid N+1 cycles after start accepted.
REQ-025 DONE holds res_iter/res_escaped stable until res_valid & res_ready, then returns to IDLE next cycle.
REQ-026 start while not IDLE is ignored; input changes after acceptance have no effect.
REQ-027 abort in OP or DONE: return to IDLE next edge, no done_tick, result discarded; abort beats start and completion in the same cycle.
REQ-028 Iteration counter never wraps: bounded by max_it ≤ 2^IW-1.

Reset
REQ-029 Reset -> IDLE; z, k, iter, thresholds, res_iter, res_escaped = 0; res_valid, busy, done_tick = 0; ready = 1.
REQ-030 Reset mid-OP or mid-DONE aborts immediately; no result emitted.

Structure
REQ-031 Package frac_pkg holds the state encoding, mode encoding, and Q-format constants (F, escape default 4.0).
REQ-032 Sub-module frac_qmul: signed Qm.f multiply, parametrised W/M, optional ×2 shift, truncated result plus overflow flag; instanced three times.

Verification (W=32, M=4, 4.0 = 0x40000000, 1.0 = 0x10000000)
REQ-033 mode=0, c=(0,0), max_it=100, thr=4.0 -> res_iter=100, res_escaped=0, res_valid 101 cycles after start.
REQ-034 mode=0, c=(1.0,0), thr=4.0 -> z 1→2→5, overflow on 3rd cycle -> res_iter=3, res_escaped=1.
REQ-035 mode=0, c=(-2.0,0), thr=4.0, max_it=50 -> 4>4 false, fixed point at 2 -> res_iter=50, res_escaped=0.
REQ-036 mode=1, z0=(0.5,0), k=(0,0), max_it=20 -> res_iter=20, res_escaped=0; max_it=0 -> res_valid next cycle, res_iter=0.
REQ-037 res_ready held low 10 cycles with start pulsed -> result stable, start ignored; then res_ready=1 -> IDLE next cycle.
REQ-038 abort, and separately reset, asserted mid-OP -> IDLE next edge, no done_tick, no res_valid; next start runs normally.

Source files
------------

// File: rtl/frac_pkg.sv
// Shared encodings and Q-format constants for the escape-time fractal engine.
package frac_pkg;

    // Engine control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Fractal family selected with start.
    typedef enum logic {
        MODE_MANDEL = 1'b0,
        MODE_JULIA  = 1'b1
    } mode_t;

    // Default Q-format: 32-bit words, 4 integer bits including sign.
    localparam int FRAC_W = 32;
    localparam int FRAC_M = 4;
    localparam int FRAC_F = FRAC_W - FRAC_M;

    // Customary escape radius squared (4.0) in the default Q4.28 format.
    localparam logic [FRAC_W-1:0] ESC_DEFAULT = 32'h4000_0000;

    // Number of fraction bits for a given word width and integer width.
    function automatic int frac_bits(input int w, input int m);
        return w - m;
    endfunction

endpackage

// File: rtl/frac_qmul.sv
// Signed Qm.f multiplier: full-precision product, rescaled to Qm.f with an
// optional extra doubling, truncated, plus a flag when the kept word cannot
// represent the true product.
module frac_qmul
    import frac_pkg::*;
#(
    parameter int W      = 32,
    parameter int M      = 4,
    parameter int DOUBLE = 0
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] p,
    output logic                ovf
);

    // Doubling the result is the same as dropping one fewer fraction bit.
    localparam int SH = frac_bits(W, M) - ((DOUBLE != 0) ? 1 : 0);

    logic signed [2*W-1:0] a_ext;
    logic signed [2*W-1:0] b_ext;
    logic signed [2*W-1:0] full;
    logic signed [2*W-1:0] shifted;

    // Operands are sign-extended to the product width so the low 2W bits of
    // the multiply are the exact signed product.
    assign a_ext = {{W{a[W-1]}}, a};
    assign b_ext = {{W{b[W-1]}}, b};
    assign full  = a_ext * b_ext;

    // Rescale to Qm.f; the arithmetic shift keeps the sign above the kept word.
    assign shifted = full >>> SH;
    assign p       = shifted[W-1:0];

    // Overflow when any discarded upper bit differs from the kept sign bit.
    assign ovf = (shifted[2*W-1:W] != {W{shifted[W-1]}});

endmodule

// File: rtl/frac_engine_mj.sv
// Mandelbrot / Julia escape-time engine: one z <- z^2 + k iteration per clock
// in signed Qm.f, reporting the iteration count and whether the orbit escaped.
module frac_engine_mj
    import frac_pkg::*;
#(
    parameter int W  = 32,
    parameter int M  = 4,
    parameter int IW = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic signed [W-1:0] cx,
    input  logic signed [W-1:0] cy,
    input  logic signed [W-1:0] jx,
    input  logic signed [W-1:0] jy,
    input  logic [IW-1:0]       max_it,
    input  logic [W-1:0]        esc_thr,
    input  logic                abort,
    output logic                ready,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [IW-1:0]       res_iter,
    output logic                res_escaped,
    output logic                done_tick
);

    state_t              state;

    // Orbit point, additive constant and per-pixel limits captured at start.
    logic signed [W-1:0] zx;
    logic signed [W-1:0] zy;
    logic signed [W-1:0] kx;
    logic signed [W-1:0] ky;
    logic [W-1:0]        thr;
    logic [IW-1:0]       max_reg;
    logic [IW-1:0]       iter;

    // Squaring datapath results for the current z.
    logic signed [W-1:0] xx;
    logic signed [W-1:0] yy;
    logic signed [W-1:0] xy2;
    logic                ovf_xx;
    logic                ovf_yy;
    logic                ovf_xy;

    logic signed [W:0]   mag2;
    logic                escape;
    logic signed [W-1:0] nx;
    logic signed [W-1:0] ny;
    logic [IW-1:0]       iter_inc;
    logic                last_it;

    frac_qmul #(.W(W), .M(M), .DOUBLE(0)) u_mul_xx (
        .a   (zx),
        .b   (zx),
        .p   (xx),
        .ovf (ovf_xx)
    );

    frac_qmul #(.W(W), .M(M), .DOUBLE(0)) u_mul_yy (
        .a   (zy),
        .b   (zy),
        .p   (yy),
        .ovf (ovf_yy)
    );

    frac_qmul #(.W(W), .M(M), .DOUBLE(1)) u_mul_xy (
        .a   (zx),
        .b   (zy),
        .p   (xy2),
        .ovf (ovf_xy)
    );

    // Escape test and next orbit point for the current iteration.
    always_comb begin
        // The magnitude is summed one bit wider so x^2+y^2 up to twice the
        // format range cannot wrap before it is compared with the threshold.
        mag2     = {xx[W-1], xx} + {yy[W-1], yy};
        escape   = ovf_xx | ovf_yy | ovf_xy | (mag2 > $signed({1'b0, thr}));
        nx       = xx - yy + kx;
        ny       = xy2 + ky;
        // iter stays below max_reg while iterating, so this never wraps.
        iter_inc = iter + 1'b1;
        last_it  = (iter_inc == max_reg);
    end

    // Control FSM with registered status outputs and the iteration datapath.
    // NOTE: every state element here uses non-blocking assignment so all
    // registers update from the same pre-edge values regardless of order.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: this design has no memory arrays, so every register, datapath
        // included, is cleared by reset to give a fully defined idle state.
        if (reset) begin
            state       <= ST_IDLE;
            zx          <= '0;
            zy          <= '0;
            kx          <= '0;
            ky          <= '0;
            thr         <= '0;
            max_reg     <= '0;
            iter        <= '0;
            res_iter    <= '0;
            res_escaped <= 1'b0;
            ready       <= 1'b1;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            done_tick   <= 1'b0;
        end else begin
            done_tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // abort in the same cycle as start wins and drops the request.
                    if (start && !abort) begin
                        zx      <= cx;
                        zy      <= cy;
                        thr     <= esc_thr;
                        max_reg <= max_it;
                        iter    <= '0;
                        if (mode_t'(mode) == MODE_JULIA) begin
                            kx <= jx;
                            ky <= jy;
                        end else begin
                            kx <= cx;
                            ky <= cy;
                        end
                        ready <= 1'b0;
                        if (max_it == '0) begin
                            // Zero iteration budget: report immediately.
                            state       <= ST_DONE;
                            res_iter    <= '0;
                            res_escaped <= 1'b0;
                            res_valid   <= 1'b1;
                            done_tick   <= 1'b1;
                        end else begin
                            state <= ST_OP;
                            busy  <= 1'b1;
                        end
                    end
                end

                ST_OP: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end else begin
                        zx   <= nx;
                        zy   <= ny;
                        iter <= iter_inc;
                        // Escape takes precedence over reaching the limit.
                        if (escape || last_it) begin
                            state       <= ST_DONE;
                            busy        <= 1'b0;
                            res_valid   <= 1'b1;
                            done_tick   <= 1'b1;
                            res_iter    <= iter_inc;
                            res_escaped <= escape;
                        end
                    end
                end

                ST_DONE: begin
                    if (abort || res_ready) begin
                        state     <= ST_IDLE;
                        res_valid <= 1'b0;
                        ready     <= 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                    ready     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frac_engine_mj.sv
// Self-checking bench for frac_engine_mj: a behavioural escape-time model
// fills a scoreboard when each pixel is started; results are popped and
// compared when the engine presents them.
module tb_frac_engine_mj;
    import frac_pkg::*;

    localparam int W  = 32;
    localparam int M  = 4;
    localparam int IW = 16;
    localparam int F  = W - M;

    localparam logic signed [W-1:0] ONE  = 32'sh1000_0000;
    localparam logic signed [W-1:0] HALF = 32'sh0800_0000;
    localparam logic [W-1:0]        THR4 = ESC_DEFAULT;

    logic                clk;
    logic                reset;
    logic                start;
    logic                mode;
    logic signed [W-1:0] cx;
    logic signed [W-1:0] cy;
    logic signed [W-1:0] jx;
    logic signed [W-1:0] jy;
    logic [IW-1:0]       max_it;
    logic [W-1:0]        esc_thr;
    logic                abort;
    logic                ready;
    logic                busy;
    logic                res_valid;
    logic                res_ready;
    logic [IW-1:0]       res_iter;
    logic                res_escaped;
    logic                done_tick;

    frac_engine_mj #(.W(W), .M(M), .IW(IW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .cx          (cx),
        .cy          (cy),
        .jx          (jx),
        .jy          (jy),
        .max_it      (max_it),
        .esc_thr     (esc_thr),
        .abort       (abort),
        .ready       (ready),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_iter    (res_iter),
        .res_escaped (res_escaped),
        .done_tick   (done_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] iter;
        logic          esc;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint t32(input longint v);
        logic signed [31:0] s;
        s = v[31:0];
        return longint'(s);
    endfunction

    // Reference escape-time computation on 64-bit integers.
    function automatic exp_t model(input logic md, input logic signed [W-1:0] c_x,
                                   input logic signed [W-1:0] c_y,
                                   input logic signed [W-1:0] j_x,
                                   input logic signed [W-1:0] j_y,
                                   input logic [IW-1:0] mi, input logic [W-1:0] th);
        exp_t   r;
        longint x, y, kx, ky, pxx, pyy, pxy, lim;
        bit     ovf;
        x   = longint'(c_x);
        y   = longint'(c_y);
        kx  = md ? longint'(j_x) : longint'(c_x);
        ky  = md ? longint'(j_y) : longint'(c_y);
        lim = longint'({32'b0, th});
        r.iter = '0;
        r.esc  = 1'b0;
        r.lat  = 1;
        if (mi == 0) return r;
        for (int n = 1; n <= int'(mi); n++) begin
            pxx = (x * x) >>> F;
            pyy = (y * y) >>> F;
            pxy = (x * y) >>> (F - 1);
            ovf = (pxx > 64'sh7fff_ffff) || (pyy > 64'sh7fff_ffff) ||
                  (pxy > 64'sh7fff_ffff) || (pxy < -64'sh8000_0000);
            if (ovf || (pxx + pyy > lim)) begin
                r.iter = IW'(n);
                r.esc  = 1'b1;
                r.lat  = n + 1;
                return r;
            end
            if (n == int'(mi)) begin
                r.iter = IW'(n);
                r.lat  = n + 1;
                return r;
            end
            x = t32(pxx - pyy + kx);
            y = t32(pxy + ky);
        end
        return r;
    endfunction

    // Start one pixel and push its expected result; inputs are scrambled
    // right after acceptance to show they are no longer looked at.
    task automatic issue(input logic md, input logic signed [W-1:0] c_x,
                         input logic signed [W-1:0] c_y, input logic signed [W-1:0] j_x,
                         input logic signed [W-1:0] j_y, input logic [IW-1:0] mi,
                         input logic [W-1:0] th);
        sb.push_back(model(md, c_x, c_y, j_x, j_y, mi, th));
        @(negedge clk);
        start   = 1'b1;
        mode    = md;
        cx      = c_x;
        cy      = c_y;
        jx      = j_x;
        jy      = j_y;
        max_it  = mi;
        esc_thr = th;
        @(posedge clk);
        #1;
        start   = 1'b0;
        mode    = ~md;
        cx      = $urandom;
        cy      = $urandom;
        jx      = $urandom;
        jy      = $urandom;
        max_it  = IW'($urandom);
        esc_thr = $urandom;
    endtask

    // Wait for the result (called #1 after the accepting edge), compare it
    // against the scoreboard, optionally stall res_ready, then retire it.
    task automatic collect(input string tag, input int hold);
        exp_t          e;
        int            cyc;
        logic [IW-1:0] it0;
        logic          es0;
        e   = sb.pop_front();
        cyc = 1;
        if (e.lat > 1) begin
            check({tag, ".busy"}, 64'(busy), 64'(1));
            check({tag, ".ready_low"}, 64'(ready), 64'(0));
        end
        while (!res_valid && cyc < 3000) begin
            if (done_tick) check({tag, ".early_tick"}, 64'(done_tick), 64'(0));
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!res_valid) begin
            check({tag, ".timeout"}, 64'(res_valid), 64'(1));
            return;
        end
        check({tag, ".iter"}, 64'(res_iter), 64'(e.iter));
        check({tag, ".esc"}, 64'(res_escaped), 64'(e.esc));
        check({tag, ".latency"}, 64'(cyc), 64'(e.lat));
        check({tag, ".tick"}, 64'(done_tick), 64'(1));
        it0 = res_iter;
        es0 = res_escaped;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            start  = 1'b1;
            max_it = 16'd0;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i == 0) check({tag, ".tick_once"}, 64'(done_tick), 64'(0));
            check({tag, ".hold_valid"}, 64'(res_valid), 64'(1));
            check({tag, ".hold_ready"}, 64'(ready), 64'(0));
            check({tag, ".hold_iter"}, 64'({es0 ^ res_escaped, res_iter}), 64'({1'b0, it0}));
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check({tag, ".ret_valid"}, 64'(res_valid), 64'(0));
        check({tag, ".ret_ready"}, 64'(ready), 64'(1));
    endtask

    // Confirm nothing is reported for a while after a cancelled pixel.
    task automatic quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (res_valid || done_tick) seen++;
        end
        check({tag, ".no_result"}, 64'(seen), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        cx        = '0;
        cy        = '0;
        jx        = '0;
        jy        = '0;
        max_it    = '0;
        esc_thr   = '0;
        abort     = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", 64'(ready), 64'(1));
        check("rst.busy", 64'(busy), 64'(0));
        check("rst.valid", 64'(res_valid), 64'(0));
        check("rst.tick", 64'(done_tick), 64'(0));
        check("rst.iter", 64'({res_escaped, res_iter}), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // Origin never escapes: full 100 iterations, latency 101.
        issue(1'b0, 32'sh0, 32'sh0, 32'sh0, 32'sh0, 16'd100, THR4);
        collect("origin", 0);

        // c=1.0: 1 -> 2 -> 5, squaring 5 overflows on the third iteration.
        issue(1'b0, ONE, 32'sh0, 32'sh0, 32'sh0, 16'd100, THR4);
        collect("c_one", 0);
        check("c_one.model", 64'(n_errors), 64'(n_errors));

        // c=-2.0: |z|^2 equals the threshold exactly and must not escape.
        issue(1'b0, -(2 * ONE), 32'sh0, 32'sh0, 32'sh0, 16'd50, THR4);
        collect("c_m2", 0);

        // Julia with k=0 from z0=0.5 shrinks toward zero.
        issue(1'b1, HALF, 32'sh0, 32'sh0, 32'sh0, 16'd20, THR4);
        collect("julia", 0);

        // Zero iteration budget reports on the next cycle.
        issue(1'b1, HALF, 32'sh0, 32'sh0, 32'sh0, 16'd0, THR4);
        collect("zero_it", 0);

        // Result held 10 cycles with start pulsed every cycle.
        issue(1'b0, ONE, 32'sh0, 32'sh0, 32'sh0, 16'd100, THR4);
        collect("hold", 10);

        // Abort mid-iteration.
        issue(1'b0, 32'sh0, 32'sh0, 32'sh0, 32'sh0, 16'd100, THR4);
        void'(sb.pop_back());
        repeat (5) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort.ready", 64'(ready), 64'(1));
        check("abort.busy", 64'(busy), 64'(0));
        quiet("abort", 110);
        issue(1'b0, -(2 * ONE), 32'sh0, 32'sh0, 32'sh0, 16'd7, THR4);
        collect("after_abort", 0);

        // Asynchronous reset mid-iteration.
        issue(1'b0, 32'sh0, 32'sh0, 32'sh0, 32'sh0, 16'd100, THR4);
        void'(sb.pop_back());
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset.ready", 64'(ready), 64'(1));
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.iter", 64'(res_iter), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        quiet("reset", 110);
        issue(1'b1, HALF, HALF, 32'sh0, ONE, 16'd30, THR4);
        collect("after_reset", 0);

        // Random pixels in both modes around the interesting region.
        for (int i = 0; i < 8; i++) begin
            logic signed [W-1:0] rx, ry, rjx, rjy;
            rx  = $signed($urandom_range(0, 32'h5000_0000)) - 32'sh2800_0000;
            ry  = $signed($urandom_range(0, 32'h3000_0000)) - 32'sh1800_0000;
            rjx = $signed($urandom_range(0, 32'h2000_0000)) - 32'sh1000_0000;
            rjy = $signed($urandom_range(0, 32'h2000_0000)) - 32'sh1000_0000;
            issue(1'(i), rx, ry, rjx, rjy, IW'($urandom_range(1, 40)), THR4);
            collect($sformatf("rand%0d", i), i % 3);
        end

        check("sb.empty", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
